switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Consumes raw board switches and turns them into clean, synchronised levels for the picoNISC core.
- Per-bit 2-flop synchroniser, then a stability counter per bit that filters bounce.
- Emits one-cycle rising-edge pulses for every switch.
- Runs a small event FSM on one designated "go" switch: the snapshot taken at the press is held until the core acknowledges it, and the switch must be released before it can re-arm.

Parameters:
- N_SW, 10, number of switch inputs.
- STABLE_CNT, 50000, consecutive clk cycles a synchronised level must persist before it is accepted; minimum 2.
- EVT_BIT, 8, index of the switch that drives the event FSM; must be < N_SW.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- nReset  input  1  asynchronous active-low reset.
- sw_in  input  N_SW  raw, asynchronous switch levels.
- sw_db  output  N_SW  debounced levels (registered).
- sw_rise  output  N_SW  one-cycle pulse when the corresponding sw_db bit goes 0->1 (registered).
- evt_pending  output  1  high while a captured event awaits acknowledge.
- evt_data  output  N_SW  sw_db snapshot taken at the event; held stable while evt_pending is high.
- evt_ack  input  1  acknowledge from the core; sampled only while evt_pending is high.

Behaviour:
- Reset (nReset low, asynchronous): sync stages, sw_db, sw_rise, counters, evt_data, evt_pending all 0; FSM in IDLE. Reset asserted mid-debounce or mid-event discards all state.
- Synchroniser: two flops per bit (s1 <= sw_in, s2 <= s1). Logic downstream uses s2 only.
- Debounce, per bit i, evaluated on each edge; counter width is $clog2(STABLE_CNT):
  - If s2[i] == sw_db[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CNT-1: sw_db[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Any glitch back to the old level restarts the count from 0. The counter never wraps.
- Latency: a clean level change on sw_in appears on sw_db at rising edge number STABLE_CNT+2. Edge 1 is the first edge that samples the new level into s1.
- sw_rise[i]: registered, asserted on the same edge sw_db[i] goes 0->1, high for exactly 1 cycle. No pulse on 1->0 transitions.
- Event FSM states: IDLE, PENDING, WAIT_RELEASE.
  - IDLE: when sw_rise[EVT_BIT]==1, capture evt_data <= sw_db (which includes EVT_BIT=1), then go to PENDING. evt_pending goes high on the next edge, i.e. 1 cycle after the sw_rise pulse.
  - PENDING: evt_pending=1 and evt_data is frozen.
    - On evt_ack=1: if sw_db[EVT_BIT]==1 go to WAIT_RELEASE, else go to IDLE.
    - evt_pending drops on the edge that samples evt_ack.
  - WAIT_RELEASE: evt_pending=0. When sw_db[EVT_BIT]==0, go to IDLE.
- Dropped events: a rising edge of EVT_BIT while the FSM is not in IDLE is dropped and does not overwrite evt_data. This cannot occur in WAIT_RELEASE, because EVT_BIT is still high there.
- evt_ack outside PENDING is ignored.
- evt_data keeps its last value after acknowledge until the next capture.
- Switches other than EVT_BIT never affect the FSM; they continue to update sw_db and sw_rise at all times.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_DROP_CNT_EN.
- When defined:
  - Adds output port evt_dropped [7:0], reset to 0.
  - Increments by 1, saturating at 255, on every edge where sw_rise[EVT_BIT]==1 and the FSM is in PENDING.
  - Cleared to 0 on the edge where an ack is accepted in PENDING; clear takes priority over increment on the same edge.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
All scenarios use STABLE_CNT=4 and N_SW=10.
1. Reset: nReset=0 asserted mid-run, asynchronous to clk -> sw_db=0, sw_rise=0, evt_pending=0, evt_data=0 immediately, without waiting for a clk edge.
2. Clean step: sw_in 0x000->0x001 held -> sw_db[0]=1 on edge 6; sw_rise[0] high for exactly that one cycle. Hold sw_in=0 for 6 edges -> sw_db returns to 0 with no pulse.
3. Bounce: sw_in[1] toggles 1,0,1,0 each cycle, then holds 1 -> sw_db[1] stays 0 throughout the bounce and becomes 1 on edge 6 after the last toggle; exactly one sw_rise[1] pulse.
4. Event and ack: sw_in=0x105 -> after debounce, evt_pending=1 one cycle after sw_rise[8], with evt_data=0x105. Change sw_in to 0x103 -> evt_data stays 0x105. Pulse evt_ack for 1 cycle -> evt_pending=0 next edge and the FSM is in WAIT_RELEASE. Release bit 8 -> FSM returns to IDLE.
5. Drop and re-arm: while PENDING, release and re-press bit 8 (fully debounced, sw_in=0x1FF) -> evt_data unchanged (evt_dropped=1 if the macro is enabled). Ack with bit 8 still held -> no new event until bit 8 is released and pressed again.
6. Stray ack: evt_ack=1 while in IDLE -> no state change, evt_pending stays 0.

Source files
------------

// File: rtl/switch_debouncer.sv
// Switch conditioner: 2-flop synchroniser, per-bit stability filter, rising-edge pulses
// and a press/ack/release event FSM on one switch. Optional SWITCH_DEBOUNCER_DROP_CNT_EN adds evt_dropped.
module switch_debouncer #(
    parameter int N_SW       = 10,
    parameter int STABLE_CNT = 50000,
    parameter int EVT_BIT    = 8
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic [N_SW-1:0] sw_in,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic            evt_pending,
    output logic [N_SW-1:0] evt_data,
`ifdef SWITCH_DEBOUNCER_DROP_CNT_EN
    output logic [7:0]      evt_dropped,
`endif
    input  logic            evt_ack
);

    localparam int CNT_W = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    typedef enum logic [1:0] {IDLE, PENDING, WAIT_RELEASE} state_t;

    logic [N_SW-1:0]            s1;
    logic [N_SW-1:0]            s2;
    logic [N_SW-1:0][CNT_W-1:0] cnt;
    logic [N_SW-1:0]            db_next;
    state_t                     state;
    state_t                     state_next;
    logic                       capture;
    logic                       ack_taken;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // A bit flips only on the cycle its mismatch count reaches the limit.
    always_comb begin
        db_next = sw_db;
        for (int i = 0; i < N_SW; i++) begin
            if (s2[i] != sw_db[i] && cnt[i] == CNT_MAX)
                db_next[i] = s2[i];
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (s2[i] == sw_db[i] || cnt[i] == CNT_MAX)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sw_db   <= '0;
            sw_rise <= '0;
        end else begin
            sw_db   <= db_next;
            sw_rise <= db_next & ~sw_db;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:         if (sw_rise[EVT_BIT]) state_next = PENDING;
            PENDING:      if (evt_ack) state_next = sw_db[EVT_BIT] ? WAIT_RELEASE : IDLE;
            WAIT_RELEASE: if (!sw_db[EVT_BIT]) state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    always_comb begin
        evt_pending = (state == PENDING);
        capture     = (state == IDLE) && sw_rise[EVT_BIT];
        ack_taken   = (state == PENDING) && evt_ack;
    end

    // Snapshot is only written from IDLE, so presses seen while busy are dropped.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            evt_data <= '0;
        else if (capture)
            evt_data <= sw_db;
    end

`ifdef SWITCH_DEBOUNCER_DROP_CNT_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            evt_dropped <= '0;
        else if (ack_taken)
            evt_dropped <= '0;
        else if (state == PENDING && sw_rise[EVT_BIT] && evt_dropped != 8'hFF)
            evt_dropped <= evt_dropped + 8'd1;
    end
`endif

endmodule
